// File: rtl/wht_pipe_n.sv
// wht_pipe_n - pipelined N-point fast Walsh-Hadamard transform, N = 2^LOG2N.
//
// Accepts one sign-magnitude N-channel vector per cycle. It produces one
// transformed vector per cycle in natural (Sylvester) order. There are
// LOG2N+2 register stages:
//   input convert -> LOG2N butterfly stages -> post-process/output.
// The whole pipe advances together and stalls as a unit on backpressure.
//
// Optional build macro WHT_OVF_FLAG_EN:
//   Defining it adds the OVF output. OVF is high for a vector in which any
//   channel saturated.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous, active-high reset
//   IN_VALID   input vector valid
//   IN_READY   engine accepts a vector this cycle
//   MODE       0 = forward, 1 = inverse (divide by N); travels with the vector
//   I_BUS      input vector, channel k at [k*W +: W], sign-magnitude
//   OUT_VALID  output vector valid
//   OUT_READY  downstream accepts the output
//   O_BUS      output vector, channel k at [k*W +: W], sign-magnitude
//   OVF        (WHT_OVF_FLAG_EN only) some channel of this vector saturated

// Per-lane output post-processing: |s|, optional /N, saturate, back to sign-magnitude.
module wht_pipe_n_lane #(
    parameter int W     = 12,
    parameter int LOG2N = 3
) (
    input  logic [W+LOG2N-1:0] sum,
    input  logic               inv,
    output logic [W-1:0]       smOut
`ifdef WHT_OVF_FLAG_EN
    ,
    output logic               sat
`endif
);
    localparam int IW = W + LOG2N;
    localparam logic [IW-1:0] MAX_MAG = IW'((1 << (W-1)) - 1);

    logic [IW-1:0] absVal;
    logic [IW-1:0] scaled;
    logic          satInt;
    logic [W-2:0]  mag;

    // |sum| always fits in IW-1 bits, so the negation cannot overflow.
    always_comb begin
        absVal = sum[IW-1] ? -sum : sum;
        scaled = inv ? (absVal >> LOG2N) : absVal;
        satInt = (scaled > MAX_MAG);
        mag    = satInt ? MAX_MAG[W-2:0] : scaled[W-2:0];
        // A zero magnitude never carries a sign. This also covers small negatives that the inverse shift truncates to 0.
        smOut  = {sum[IW-1] && (mag != '0), mag};
    end

`ifdef WHT_OVF_FLAG_EN
    assign sat = satInt;
`endif
endmodule

module wht_pipe_n #(
    parameter int W     = 12,
    parameter int LOG2N = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic                    MODE,
    input  logic [(W<<LOG2N)-1:0]   I_BUS,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [(W<<LOG2N)-1:0]   O_BUS
`ifdef WHT_OVF_FLAG_EN
    ,
    output logic                    OVF
`endif
);
    localparam int N      = 1 << LOG2N;
    localparam int IW     = W + LOG2N;
    localparam int STAGES = LOG2N + 1;

    // vldPipe[0] is the capture stage, vldPipe[1..LOG2N] are the butterflies, and vldPipe[STAGES] is the output register.
    logic [STAGES:0]         vldPipe;
    logic                    advance;
    logic [N-1:0][IW-1:0]    inConv;
    logic [N-1:0][IW-1:0]    stg [0:LOG2N];
    logic [N-1:0][IW-1:0]    bf  [1:LOG2N];
    logic [LOG2N:0]          modeStg;
    logic [N-1:0][W-1:0]     outSm;
    logic [N-1:0][W-1:0]     oBusQ;
`ifdef WHT_OVF_FLAG_EN
    logic [N-1:0]            satVec;
    logic                    ovfQ;
`endif

    assign OUT_VALID = vldPipe[STAGES];
    assign advance   = !OUT_VALID || OUT_READY;
    assign IN_READY  = advance;
    assign O_BUS     = oBusQ;
`ifdef WHT_OVF_FLAG_EN
    assign OVF       = ovfQ;
`endif

    // Convert sign-magnitude input to two's complement. Negative zero becomes 0 naturally.
    for (genvar k = 0; k < N; k++) begin : gIn
        logic [IW-1:0] magExt;
        assign magExt    = {{(LOG2N+1){1'b0}}, I_BUS[k*W +: W-1]};
        assign inConv[k] = I_BUS[k*W+W-1] ? -magExt : magExt;
    end

    // Butterfly stage s pairs channel i with its partner i ^ span, where span = 2^(s-1).
    always_comb begin
        for (int s = 1; s <= LOG2N; s++) begin
            bf[s] = '0;
            for (int i = 0; i < N; i++) begin
                if ((i & (1 << (s-1))) == 0)
                    bf[s][i] = stg[s-1][i] + stg[s-1][i ^ (1 << (s-1))];
                else
                    bf[s][i] = stg[s-1][i ^ (1 << (s-1))] - stg[s-1][i];
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : gLane
        wht_pipe_n_lane #(.W(W), .LOG2N(LOG2N)) uLane (
            .sum   (stg[LOG2N][k]),
            .inv   (modeStg[LOG2N]),
            .smOut (outSm[k])
`ifdef WHT_OVF_FLAG_EN
            ,
            .sat   (satVec[k])
`endif
        );
    end

    // Data registers load only behind a valid. This means bubbles leave the last O_BUS value in place instead of toggling it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            vldPipe <= '0;
            modeStg <= '0;
            oBusQ   <= '0;
            for (int s = 0; s <= LOG2N; s++) stg[s] <= '0;
`ifdef WHT_OVF_FLAG_EN
            ovfQ    <= 1'b0;
`endif
        end else if (advance) begin
            vldPipe <= {vldPipe[STAGES-1:0], IN_VALID};
            if (IN_VALID) begin
                stg[0]     <= inConv;
                modeStg[0] <= MODE;
            end
            for (int s = 1; s <= LOG2N; s++) begin
                if (vldPipe[s-1]) begin
                    stg[s]     <= bf[s];
                    modeStg[s] <= modeStg[s-1];
                end
            end
            if (vldPipe[LOG2N]) begin
                oBusQ <= outSm;
`ifdef WHT_OVF_FLAG_EN
                ovfQ  <= |satVec;
`endif
            end
        end
    end
endmodule

// File: tb/tb_wht_pipe_n.sv
// tb_wht_pipe_n - directed self-checking bench for wht_pipe_n (W=12, N=8).
// A negedge monitor compares every output transfer against a queue of
// expected vectors. The queue holds hand-computed constants for the listed
// cases. For the streamed vectors it holds values from a direct O(N^2)
// Hadamard sum.
module tb_wht_pipe_n;
    localparam int W     = 12;
    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int BW    = W * N;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          IN_VALID;
    logic          IN_READY;
    logic          MODE;
    logic [BW-1:0] I_BUS;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [BW-1:0] O_BUS;
`ifdef WHT_OVF_FLAG_EN
    logic          OVF;
`endif

    int checks = 0;
    int errors = 0;
    int outCnt = 0;
    int pushCnt = 0;
    int spurious = 0;
    logic [BW-1:0] expQ[$];
    logic          ovfQ[$];

    wht_pipe_n #(.W(W), .LOG2N(LOG2N)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .MODE      (MODE),
        .I_BUS     (I_BUS),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .O_BUS     (O_BUS)
`ifdef WHT_OVF_FLAG_EN
        ,
        .OVF       (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] pk(input logic [11:0] c0, c1, c2, c3, c4, c5, c6, c7);
        return {c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    // Direct Hadamard sum: y[k] = sum_i x[i] * (-1)^popcount(i&k).
    function automatic logic [BW-1:0] refWht(input logic [BW-1:0] v, input logic m, output logic ovf);
        logic [BW-1:0] r;
        int acc, x, mag;
        logic [11:0] c;
        r = '0;
        ovf = 1'b0;
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int i = 0; i < N; i++) begin
                c = v[i*W +: W];
                x = c[11] ? -int'(c[10:0]) : int'(c[10:0]);
                if ($countones(i & k) % 2 == 1) acc -= x;
                else acc += x;
            end
            mag = (acc < 0) ? -acc : acc;
            if (m) mag = mag / N;
            if (mag > 2047) begin
                mag = 2047;
                ovf = 1'b1;
            end
            r[k*W +: W] = {(acc < 0) && (mag != 0), 11'(mag)};
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] mkVec(input int j);
        logic [BW-1:0] v;
        int mag;
        for (int k = 0; k < N; k++) begin
            mag = (j * 173 + k * 311 + 5) % 2048;
            v[k*W +: W] = {((j + k) % 3 == 0), 11'(mag)};
        end
        return v;
    endfunction

    // Hold the vector on the bus until it is accepted; leaves time at posedge+1.
    task automatic push(input logic [BW-1:0] v, input logic m, input logic track,
                        input logic [BW-1:0] e, input logic eo);
        logic rdy;
        int guard;
        if (track) begin
            expQ.push_back(e);
            ovfQ.push_back(eo);
            pushCnt++;
        end
        I_BUS = v;
        MODE = m;
        IN_VALID = 1'b1;
        guard = 0;
        do begin
            @(negedge CLK);
            rdy = IN_READY;
            @(posedge CLK);
            #1;
            guard++;
        end while (!rdy && guard < 50);
        if (!rdy) chk("accept_timeout", rdy, 1'b1);
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (expQ.size() != 0 && guard < 100) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        chk("drain", expQ.size(), 0);
    endtask

    always @(negedge CLK) begin
        if (!RESET && OUT_VALID && OUT_READY) begin
            outCnt++;
            if (expQ.size() == 0) spurious++;
            else begin
                chk("out_data", O_BUS, expQ[0]);
`ifdef WHT_OVF_FLAG_EN
                chk("out_ovf", OVF, ovfQ[0]);
`endif
                void'(expQ.pop_front());
                void'(ovfQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] vA, fwdA, invA, v, e;
        logic eo;
        int lat;

        RESET = 1'b1;
        IN_VALID = 1'b0;
        MODE = 1'b0;
        I_BUS = '0;
        OUT_READY = 1'b1;
        #12;
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_o_bus", O_BUS, '0);
        chk("rst_in_ready", IN_READY, 1'b1);
`ifdef WHT_OVF_FLAG_EN
        chk("rst_ovf", OVF, 1'b0);
`endif
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // Forward and inverse on the reference vector, plus a latency check.
        vA   = pk(12'h016, 12'h003, 12'h004, 12'h801, 12'h006, 12'h007, 12'h004, 12'h802);
        fwdA = pk(12'h02B, 12'h01D, 12'h021, 12'h007, 12'h00D, 12'h013, 12'h00B, 12'h015);
        invA = pk(12'h005, 12'h003, 12'h004, 12'h000, 12'h001, 12'h002, 12'h001, 12'h002);
        push(vA, 1'b0, 1'b1, fwdA, 1'b0);
        lat = 1;
        while (!OUT_VALID && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        chk("latency", lat, 5);
        drain();

        // Back-to-back: inverse, saturation corners, negative zero.
        push(vA, 1'b1, 1'b1, invA, 1'b0);
        push({N{12'h7FF}}, 1'b0, 1'b1, pk(12'h7FF, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        push({N{12'hFFF}}, 1'b0, 1'b1, pk(12'hFFF, 0, 0, 0, 0, 0, 0, 0), 1'b1);
        push({N{12'h800}}, 1'b0, 1'b1, '0, 1'b0);
        push({N{12'h800}}, 1'b1, 1'b1, '0, 1'b0);
        // Inverse of full-scale lands exactly on the max magnitude, so it does not saturate.
        push({N{12'h7FF}}, 1'b1, 1'b1, pk(12'h7FF, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        push({N{12'hFFF}}, 1'b1, 1'b1, pk(12'hFFF, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        // Mixed modes at full rate.
        push(vA, 1'b0, 1'b1, fwdA, 1'b0);
        push(vA, 1'b1, 1'b1, invA, 1'b0);
        push(vA, 1'b0, 1'b1, fwdA, 1'b0);
        drain();

        // Backpressure: 8 distinct vectors with a 3-cycle OUT_READY gap mid-stream.
        fork
            begin
                for (int j = 0; j < 8; j++) begin
                    v = mkVec(j);
                    e = refWht(v, 1'(j % 2), eo);
                    push(v, 1'(j % 2), 1'b1, e, eo);
                end
            end
            begin
                repeat (7) @(posedge CLK);
                #1;
                OUT_READY = 1'b0;
                repeat (3) begin
                    @(negedge CLK);
                    chk("stall_in_ready", IN_READY, 1'b0);
                    chk("stall_out_valid", OUT_VALID, 1'b1);
                    chk("stall_hold", O_BUS, expQ[0]);
                    @(posedge CLK);
                    #1;
                end
                OUT_READY = 1'b1;
            end
        join
        drain();

        // Reset with vectors in flight and one parked on the output.
        OUT_READY = 1'b0;
        for (int j = 0; j < 3; j++) push(mkVec(j + 20), 1'b0, 1'b0, '0, 1'b0);
        lat = 0;
        while (!OUT_VALID && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        chk("pre_reset_valid", OUT_VALID, 1'b1);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst_valid", OUT_VALID, 1'b0);
        chk("async_rst_o_bus", O_BUS, '0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        OUT_READY = 1'b1;
        repeat (12) @(posedge CLK);
        #1;

        chk("spurious_outputs", spurious, 0);
        chk("out_count", outCnt, pushCnt);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
